mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter ADDR_W, default 19, sets the word address width on both sides.
REQ-002 Parameter DATA_W, default 256, sets the data width; STRB_W = DATA_W/8 (32) sets the byte-strobe width.
REQ-003 clk_i  in  1  single clock; all state changes on the rising edge.
REQ-004 arst_i  in  1  reset, synchronous, active-high.
REQ-005 rN_iob_valid_i  in  1  request valid from requester N (N = 0, 1).
REQ-006 rN_iob_addr_i  in  ADDR_W  request word address.
REQ-007 rN_iob_wdata_i  in  DATA_W  write data.
REQ-008 rN_iob_wstrb_i  in  STRB_W  byte strobes; all-zero marks a read.
REQ-009 rN_iob_rdata_o  out  DATA_W  read data; a copy of m_iob_rdata_i, meaningful only with rvalid.
REQ-010 rN_iob_rvalid_o  out  1  read data valid, one cycle.
REQ-011 rN_iob_ready_o  out  1  request accepted this cycle.
REQ-012 m_iob_valid_o, m_iob_addr_o, m_iob_wdata_o, m_iob_wstrb_o  out  1/ADDR_W/DATA_W/STRB_W  request to the shared memory_wrapper port.
REQ-013 m_iob_rdata_i  in  DATA_W; m_iob_rvalid_i  in  1; m_iob_ready_i  in  1  memory response and accept.
REQ-014 grant_o  out  2  one-hot owner of the memory port; 00 when idle.
REQ-015 busy_o  out  1  high in any state other than IDLE.

Function
REQ-016 The FSM SHALL have three states: IDLE, ISSUE and WAIT_RD.
REQ-017 IDLE, any rN_iob_valid_i high: register the grant, go to ISSUE next cycle (one cycle of arbitration latency).
REQ-018 Both requesters valid in IDLE: the grant goes to the requester that was not granted last (round-robin).
REQ-019 last_grant SHALL reset to 1, so requester 0 wins the first tie.
REQ-020 last_grant SHALL update only when a request is accepted; an aborted grant does not update it.
REQ-021 ISSUE: m_iob_valid_o = 1; address, data and strobes muxed combinationally from the granted requester; granted rN_iob_ready_o = m_iob_ready_i.
REQ-022 ISSUE, accept (m_iob_valid_o & m_iob_ready_i): if wstrb is zero, go to WAIT_RD; otherwise go to IDLE, and the write completes at acceptance.
REQ-023 ISSUE, granted requester drops valid before acceptance: go to IDLE with no memory access (abort).
REQ-024 WAIT_RD: m_iob_valid_o = 0; on m_iob_rvalid_i, pulse rvalid to the granted requester in the same cycle (combinational) and go to IDLE.
REQ-025 WAIT_RD SHALL wait with no limit on the number of cycles.
REQ-026 The non-granted requester SHALL see ready_o = 0 and rvalid_o = 0 in all states.
REQ-027 m_iob_rvalid_i outside WAIT_RD SHALL be ignored and not forwarded.
REQ-028 At most one transaction SHALL be outstanding; a new grant is possible only from IDLE, so back-to-back requests from one requester take at least 2 cycles each.
REQ-029 A requester holding valid across a completion while the other also requests SHALL lose the next arbitration (no starvation).
REQ-030 In IDLE, m_iob_valid_o = 0 and m_iob_addr_o/wdata_o/wstrb_o = 0.

Reset
REQ-031 While arst_i is high, at the clock edge: state = IDLE, grant = 00, last_grant = 1.
REQ-032 While arst_i is high, outputs: m_iob_valid_o = 0, all ready_o/rvalid_o = 0, busy_o = 0.
REQ-033 Reset asserted in ISSUE or WAIT_RD SHALL abandon the transaction.
REQ-034 Read data arriving after such a reset SHALL be dropped.

Verification
REQ-035 Single write: r0 writes addr 0x00005, wdata 0xDEADBEEF...6677, wstrb 0xFFFFFFFF, memory ready after 2 cycles -> r0 ready pulses once, grant_o = 01, FSM back to IDLE, no rvalid.
REQ-036 Read-back: r0 reads 0x00005 with wstrb 0, rvalid after 3 cycles -> r0_iob_rvalid_o pulses 1 cycle with the written data; r1_iob_rvalid_o stays 0.
REQ-037 Simultaneous requests from reset: r0 reads 0x00006, r1 writes 0x00007 -> r0 served first, then r1; grant_o sequence 01 then 10.
REQ-038 Both requesters held valid for 6 transactions -> grants strictly alternate 0,1,0,1,0,1.
REQ-039 Abort: r1 drops valid in ISSUE with m_iob_ready_i = 0 -> no memory accept, FSM returns to IDLE, and r1 keeps priority at the next tie.
REQ-040 Reset in WAIT_RD, then m_iob_rvalid_i one cycle after reset release -> no rvalid_o on either requester, busy_o = 0.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Two-requester round-robin arbiter in front of a single memory_wrapper port.
// Holds at most one transaction in flight and returns read data to the requester that issued it.
module mem_port_arbiter #(
  parameter int ADDR_W = 19,
  parameter int DATA_W = 256,
  parameter int STRB_W = DATA_W / 8
) (
  input  logic              clk_i,
  input  logic              arst_i,

  input  logic              r0_iob_valid_i,
  input  logic [ADDR_W-1:0] r0_iob_addr_i,
  input  logic [DATA_W-1:0] r0_iob_wdata_i,
  input  logic [STRB_W-1:0] r0_iob_wstrb_i,
  output logic [DATA_W-1:0] r0_iob_rdata_o,
  output logic              r0_iob_rvalid_o,
  output logic              r0_iob_ready_o,

  input  logic              r1_iob_valid_i,
  input  logic [ADDR_W-1:0] r1_iob_addr_i,
  input  logic [DATA_W-1:0] r1_iob_wdata_i,
  input  logic [STRB_W-1:0] r1_iob_wstrb_i,
  output logic [DATA_W-1:0] r1_iob_rdata_o,
  output logic              r1_iob_rvalid_o,
  output logic              r1_iob_ready_o,

  output logic              m_iob_valid_o,
  output logic [ADDR_W-1:0] m_iob_addr_o,
  output logic [DATA_W-1:0] m_iob_wdata_o,
  output logic [STRB_W-1:0] m_iob_wstrb_o,
  input  logic [DATA_W-1:0] m_iob_rdata_i,
  input  logic              m_iob_rvalid_i,
  input  logic              m_iob_ready_i,

  output logic [1:0]        grant_o,
  output logic              busy_o
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_RD
  } state_t;

  state_t      state_q;
  logic [1:0]  grant_q;
  logic        last_grant_q;  // index of the requester whose request was last accepted

  logic [1:0]  next_grant;
  logic        sel_valid;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic [STRB_W-1:0] sel_wstrb;
  logic        in_issue;
  logic        in_wait;
  logic        accept;

  // Round-robin pick: on a tie the requester that did not win last time goes first.
  always_comb begin
    next_grant = 2'b00;
    if (r0_iob_valid_i && r1_iob_valid_i) begin
      next_grant = last_grant_q ? 2'b01 : 2'b10;
    end else if (r0_iob_valid_i) begin
      next_grant = 2'b01;
    end else if (r1_iob_valid_i) begin
      next_grant = 2'b10;
    end
  end

  always_comb begin
    sel_valid = r0_iob_valid_i;
    sel_addr  = r0_iob_addr_i;
    sel_wdata = r0_iob_wdata_i;
    sel_wstrb = r0_iob_wstrb_i;
    if (grant_q[1]) begin
      sel_valid = r1_iob_valid_i;
      sel_addr  = r1_iob_addr_i;
      sel_wdata = r1_iob_wdata_i;
      sel_wstrb = r1_iob_wstrb_i;
    end
  end

  // NOTE: reset is synchronous, so the registered state is stale during the cycle reset
  // is held; every handshake output is gated with arst_i so nothing leaks out before the edge.
  assign in_issue = (state_q == ISSUE)   && !arst_i;
  assign in_wait  = (state_q == WAIT_RD) && !arst_i;
  assign accept   = in_issue && sel_valid && m_iob_ready_i;

  assign m_iob_valid_o = in_issue && sel_valid;
  assign m_iob_addr_o  = in_issue ? sel_addr  : '0;
  assign m_iob_wdata_o = in_issue ? sel_wdata : '0;
  assign m_iob_wstrb_o = in_issue ? sel_wstrb : '0;

  assign r0_iob_ready_o  = accept && grant_q[0];
  assign r1_iob_ready_o  = accept && grant_q[1];
  assign r0_iob_rvalid_o = in_wait && grant_q[0] && m_iob_rvalid_i;
  assign r1_iob_rvalid_o = in_wait && grant_q[1] && m_iob_rvalid_i;
  assign r0_iob_rdata_o  = m_iob_rdata_i;
  assign r1_iob_rdata_o  = m_iob_rdata_i;

  assign grant_o = grant_q;
  assign busy_o  = (state_q != IDLE) && !arst_i;

  // NOTE: all state is updated with non-blocking assignments so every register
  // sees the pre-edge values of the others, regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (arst_i) begin
      state_q      <= IDLE;
      grant_q      <= 2'b00;
      last_grant_q <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (r0_iob_valid_i || r1_iob_valid_i) begin
            grant_q <= next_grant;
            state_q <= ISSUE;
          end
        end
        ISSUE: begin
          if (accept) begin
            last_grant_q <= grant_q[1];
            if (sel_wstrb == '0) begin
              state_q <= WAIT_RD;
            end else begin
              state_q <= IDLE;
              grant_q <= 2'b00;
            end
          end else if (!sel_valid) begin
            // Requester withdrew before the memory took it: abort without touching priority.
            state_q <= IDLE;
            grant_q <= 2'b00;
          end
        end
        WAIT_RD: begin
          if (m_iob_rvalid_i) begin
            state_q <= IDLE;
            grant_q <= 2'b00;
          end
        end
        default: begin
          state_q <= IDLE;
          grant_q <= 2'b00;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus randomized
// transactions checked against a transaction-level round-robin and memory model.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

  localparam int AW = 19;
  localparam int DW = 256;
  localparam int SW = 32;
  localparam logic [DW-1:0] WD = 256'hDEADBEEF_CAFEBABE_0123456789ABCDEF_FEDCBA9876543210_0011223344556677;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          arst;
  logic          v  [2];
  logic [AW-1:0] a  [2];
  logic [DW-1:0] wd [2];
  logic [SW-1:0] ws [2];
  logic [DW-1:0] rd0, rd1;
  logic          rv0, rv1, rdy0, rdy1;
  logic          m_valid, m_rvalid, m_ready;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata, m_rdata;
  logic [SW-1:0] m_wstrb;
  logic [1:0]    grant;
  logic          busy;

  int checks = 0;
  int failures = 0;
  int last_w;
  int exp_acc = 0;
  int acc_cnt = 0;
  int exp_rv[2] = '{0, 0};
  int rv_cnt[2] = '{0, 0};
  logic [DW-1:0] mem [int];
  logic [1:0]    gq [$];
  logic [DW-1:0] last_rdata;

  mem_port_arbiter dut (
    .clk_i           (clk),
    .arst_i          (arst),
    .r0_iob_valid_i  (v[0]),
    .r0_iob_addr_i   (a[0]),
    .r0_iob_wdata_i  (wd[0]),
    .r0_iob_wstrb_i  (ws[0]),
    .r0_iob_rdata_o  (rd0),
    .r0_iob_rvalid_o (rv0),
    .r0_iob_ready_o  (rdy0),
    .r1_iob_valid_i  (v[1]),
    .r1_iob_addr_i   (a[1]),
    .r1_iob_wdata_i  (wd[1]),
    .r1_iob_wstrb_i  (ws[1]),
    .r1_iob_rdata_o  (rd1),
    .r1_iob_rvalid_o (rv1),
    .r1_iob_ready_o  (rdy1),
    .m_iob_valid_o   (m_valid),
    .m_iob_addr_o    (m_addr),
    .m_iob_wdata_o   (m_wdata),
    .m_iob_wstrb_o   (m_wstrb),
    .m_iob_rdata_i   (m_rdata),
    .m_iob_rvalid_i  (m_rvalid),
    .m_iob_ready_i   (m_ready),
    .grant_o         (grant),
    .busy_o          (busy)
  );

  always @(posedge clk) begin
    if (m_valid && m_ready) acc_cnt++;
    if (rv0) rv_cnt[0]++;
    if (rv1) rv_cnt[1]++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] mem_rd(input int ad);
    return mem.exists(ad) ? mem[ad] : '0;
  endfunction

  task automatic mem_wr(input int ad, input logic [DW-1:0] d, input logic [SW-1:0] s);
    logic [DW-1:0] cur;
    cur = mem_rd(ad);
    for (int b = 0; b < SW; b++) if (s[b]) cur[8*b +: 8] = d[8*b +: 8];
    mem[ad] = cur;
  endtask

  task automatic new_req(input int n);
    v[n] = 1'b1;
    a[n] = AW'($urandom_range(0, 15));
    for (int i = 0; i < 8; i++) wd[n][32*i +: 32] = $urandom;
    ws[n] = ($urandom_range(0, 1) == 1) ? '0 : SW'($urandom);
  endtask

  task automatic issue_chk(input int w, input logic [1:0] g_exp, input logic rdy_exp);
    chk("iss_grant", grant, g_exp);
    chk("iss_busy", busy, 1'b1);
    chk("iss_mvalid", m_valid, 1'b1);
    chk("iss_maddr", m_addr, a[w]);
    chk("iss_mwdata", m_wdata, wd[w]);
    chk("iss_mwstrb", m_wstrb, ws[w]);
    chk("iss_ready_win", (w == 1) ? rdy1 : rdy0, rdy_exp);
    chk("iss_ready_lose", (w == 1) ? rdy0 : rdy1, 1'b0);
    chk("iss_rvalid0", rv0, 1'b0);
    chk("iss_rvalid1", rv1, 1'b0);
  endtask

  // One full transaction from IDLE; the winner comes from the round-robin model.
  task automatic run_txn(input int lat_rdy, input int lat_rd, input bit keep);
    int w;
    bit is_rd;
    logic [AW-1:0] ad;
    logic [1:0] g_exp;
    w = (v[0] && v[1]) ? 1 - last_w : (v[0] ? 0 : 1);
    g_exp = (w == 0) ? 2'b01 : 2'b10;
    #1;
    chk("idle_busy", busy, 1'b0);
    chk("idle_grant", grant, 2'b00);
    chk("idle_mvalid", m_valid, 1'b0);
    chk("idle_maddr", m_addr, '0);
    chk("idle_mwdata", m_wdata, '0);
    chk("idle_mwstrb", m_wstrb, '0);
    tick();
    gq.push_back(grant);
    is_rd = (ws[w] == '0);
    ad = a[w];
    for (int k = 0; k < lat_rdy; k++) begin
      m_rvalid = 1'($urandom_range(0, 1));
      #1;
      issue_chk(w, g_exp, 1'b0);
      tick();
      m_rvalid = 1'b0;
    end
    m_ready = 1'b1;
    #1;
    issue_chk(w, g_exp, 1'b1);
    if (!is_rd) mem_wr(int'(ad), wd[w], ws[w]);
    exp_acc++;
    last_w = w;
    tick();
    m_ready = 1'b0;
    if (keep) new_req(w);
    else v[w] = 1'b0;
    if (is_rd) begin
      for (int k = 0; k < lat_rd; k++) begin
        #1;
        chk("wait_busy", busy, 1'b1);
        chk("wait_mvalid", m_valid, 1'b0);
        chk("wait_grant", grant, g_exp);
        chk("wait_rvalid0", rv0, 1'b0);
        chk("wait_rvalid1", rv1, 1'b0);
        tick();
      end
      m_rdata = mem_rd(int'(ad));
      m_rvalid = 1'b1;
      #1;
      chk("rd_rvalid_win", (w == 1) ? rv1 : rv0, 1'b1);
      chk("rd_rvalid_lose", (w == 1) ? rv0 : rv1, 1'b0);
      last_rdata = (w == 1) ? rd1 : rd0;
      chk("rd_data", last_rdata, mem_rd(int'(ad)));
      exp_rv[w]++;
      tick();
      m_rvalid = 1'b0;
      for (int i = 0; i < 8; i++) m_rdata[32*i +: 32] = $urandom;
    end
    #1;
    chk("done_busy", busy, 1'b0);
    chk("done_grant", grant, 2'b00);
  endtask

  task automatic do_reset();
    arst = 1'b1;
    v[0] = 1'b0;
    v[1] = 1'b0;
    m_ready = 1'b0;
    m_rvalid = 1'b0;
    #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_mvalid", m_valid, 1'b0);
    chk("rst_ready0", rdy0, 1'b0);
    chk("rst_ready1", rdy1, 1'b0);
    tick();
    tick();
    chk("rst_grant", grant, 2'b00);
    arst = 1'b0;
    last_w = 1;
  endtask

  initial begin
    for (int n = 0; n < 2; n++) begin
      a[n] = '0;
      wd[n] = '0;
      ws[n] = '0;
    end
    m_rdata = '0;
    last_rdata = '0;
    do_reset();

    // Single write from r0, memory ready after 2 cycles.
    v[0] = 1'b1; a[0] = 19'h00005; wd[0] = WD; ws[0] = 32'hFFFF_FFFF;
    run_txn(2, 0, 0);
    chk("wr_grant", gq[0], 2'b01);
    chk("wr_no_rvalid", rv_cnt[0] + rv_cnt[1], 0);
    chk("wr_accepts", acc_cnt, 1);

    // Read-back of the same word, data after 3 cycles.
    v[0] = 1'b1; a[0] = 19'h00005; ws[0] = '0;
    run_txn(0, 3, 0);
    chk("readback_data", last_rdata, WD);
    chk("readback_r0_pulses", rv_cnt[0], 1);
    chk("readback_r1_pulses", rv_cnt[1], 0);

    // Simultaneous requests straight out of reset: r0 first, then r1.
    do_reset();
    gq.delete();
    v[0] = 1'b1; a[0] = 19'h00006; ws[0] = '0;
    v[1] = 1'b1; a[1] = 19'h00007; wd[1] = ~WD; ws[1] = 32'h0000_FFFF;
    run_txn(1, 2, 0);
    run_txn(0, 0, 0);
    chk("tie_first", gq[0], 2'b01);
    chk("tie_second", gq[1], 2'b10);

    // Both held valid: grants must alternate 0,1,0,1,0,1.
    gq.delete();
    new_req(0);
    new_req(1);
    for (int i = 0; i < 6; i++) run_txn(int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), 1'b1);
    for (int i = 0; i < 6; i++) chk("alternate", gq[i], (i % 2 == 1) ? 2'b10 : 2'b01);

    // Abort: give r1 priority, then let it withdraw in ISSUE.
    v[1] = 1'b0;
    new_req(0);
    run_txn(0, 0, 0);
    new_req(0);
    new_req(1);
    #1;
    tick();
    chk("abort_grant", grant, 2'b10);
    v[1] = 1'b0;
    #1;
    chk("abort_ready1", rdy1, 1'b0);
    chk("abort_ready0", rdy0, 1'b0);
    tick();
    #1;
    chk("abort_idle_busy", busy, 1'b0);
    chk("abort_idle_grant", grant, 2'b00);
    chk("abort_no_accept", acc_cnt, exp_acc);
    new_req(1);
    run_txn(1, 1, 0);
    chk("abort_keeps_priority", gq[$], 2'b10);

    // Reset while waiting for read data; late rvalid must be dropped.
    v[0] = 1'b0;
    v[1] = 1'b0;
    tick();
    v[0] = 1'b1; a[0] = 19'h00008; ws[0] = '0;
    tick();
    m_ready = 1'b1;
    #1;
    chk("rstwait_ready0", rdy0, 1'b1);
    tick();
    m_ready = 1'b0;
    v[0] = 1'b0;
    exp_acc++;
    #1;
    chk("rstwait_busy_before", busy, 1'b1);
    arst = 1'b1;
    m_rvalid = 1'b1;
    #1;
    chk("rstwait_busy_in_rst", busy, 1'b0);
    chk("rstwait_rv0_in_rst", rv0, 1'b0);
    chk("rstwait_rv1_in_rst", rv1, 1'b0);
    chk("rstwait_mvalid_in_rst", m_valid, 1'b0);
    tick();
    m_rvalid = 1'b0;
    #1;
    chk("rstwait_grant", grant, 2'b00);
    arst = 1'b0;
    last_w = 1;
    tick();
    m_rvalid = 1'b1;
    #1;
    chk("late_rv0", rv0, 1'b0);
    chk("late_rv1", rv1, 1'b0);
    chk("late_busy", busy, 1'b0);
    tick();
    m_rvalid = 1'b0;
    new_req(0);
    new_req(1);
    run_txn(0, 1, 0);
    chk("post_rst_tie", gq[$], 2'b01);

    // Randomized traffic against the model.
    for (int i = 0; i < 40; i++) begin
      for (int n = 0; n < 2; n++) if (!v[n] && $urandom_range(0, 2) != 0) new_req(n);
      if (!v[0] && !v[1]) new_req(int'($urandom_range(0, 1)));
      run_txn(int'($urandom_range(0, 3)),
              ($urandom_range(0, 7) == 0) ? 20 : int'($urandom_range(0, 3)),
              1'($urandom_range(0, 1)));
    end

    v[0] = 1'b0;
    v[1] = 1'b0;
    tick();
    chk("accept_count", acc_cnt, exp_acc);
    chk("rvalid_count0", rv_cnt[0], exp_rv[0]);
    chk("rvalid_count1", rv_cnt[1], exp_rv[1]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
